// File: rtl/uart_tx_if.sv
// Host-side byte interface and serial pin of the UART transmitter.
// The host drives the tick, request and data; the transmitter drives the line and status.
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            baud_rate;
    logic            tx_start;
    logic [DBIT-1:0] d_in;
    logic            tx;
    logic            tx_busy;
    logic            tx_done;

    modport master (
        output baud_rate, tx_start, d_in,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  baud_rate, tx_start, d_in,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DBIT data bits MSB first, 1 stop bit, no parity,
// each bit lasting SB_TICK ticks of the 16x oversampling baud_rate strobe.
//
//   state | meaning
//   IDLE  | line high, waiting for tx_start
//   START | driving start bit (0)
//   DATA  | driving shift register MSB, DBIT bits
//   STOP  | driving stop bit (1), tx_done on exit
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);
    localparam int TW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    shift_d = bus.d_in;
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bus.baud_rate) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.baud_rate) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q << 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (bus.baud_rate) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level and busy are decoded from the next state so they stay registered
        // yet line up with the state they describe.
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[DBIT-1];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level model of the line, plus a
// behavioural mid-bit-sampling receiver on tx for loopback.
module tb_uart_tx;
    localparam int SB    = 16;
    localparam int TOTAL = 10 * SB;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_tx_if #(.DBIT(8)) bus ();

    uart_tx #(.DBIT(8), .SB_TICK(SB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural receiver sharing baud_rate: find start, sample mid-bit, MSB first.
    int         rx_st = 0;
    int         rx_s = 0;
    int         rx_nb = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    int         rx_done_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            rx_st <= 0;
        end else begin
            case (rx_st)
                0: if (bus.tx == 1'b0) begin rx_st <= 1; rx_s <= 0; end
                1: if (bus.baud_rate) begin
                    if (rx_s == 7) begin rx_st <= 2; rx_s <= 0; rx_nb <= 0; end
                    else rx_s <= rx_s + 1;
                end
                2: if (bus.baud_rate) begin
                    if (rx_s == 15) begin
                        rx_s  <= 0;
                        rx_sh <= {rx_sh[6:0], bus.tx};
                        if (rx_nb == 7) rx_st <= 3;
                        else rx_nb <= rx_nb + 1;
                    end else rx_s <= rx_s + 1;
                end
                3: if (bus.baud_rate) begin
                    if (rx_s == 15) begin
                        rx_st       <= 0;
                        rx_byte     <= rx_sh;
                        rx_done_cnt <= rx_done_cnt + 1;
                    end else rx_s <= rx_s + 1;
                end
                default: rx_st <= 0;
            endcase
        end
    end

    // Sends one frame starting in the current (idle or tx_done) cycle and checks
    // {tx,busy,done} every cycle: after n consumed ticks the line carries bit n/16
    // of {start, data[7:0], stop}; at n==160 tx_done is high and busy low.
    task automatic run_frame(input string name, input logic [7:0] data, input int period,
                             input bit hold_start, input int change_at, input int abort_at,
                             output int edges);
        logic [9:0] bits;
        logic [2:0] exp;
        logic [2:0] got;
        int         n;
        int         ph;
        bit         tick;
        bits  = {1'b0, data, 1'b1};
        n     = 0;
        ph    = 0;
        edges = 0;
        bus.d_in      = data;
        bus.tx_start  = 1'b1;
        bus.baud_rate = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (1) begin
            if (n < TOTAL) exp = {bits[9 - n / SB], 2'b10};
            else           exp = 3'b101;
            got = {bus.tx, bus.tx_busy, bus.tx_done};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s line n=%0d edge=%0d {tx,busy,done} got %b want %b",
                         name, n, edges, got, exp);
            end
            if (n >= TOTAL) break;
            if (n == abort_at) begin
                reset        = 1'b1;
                bus.tx_start = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (!hold_start) bus.tx_start = 1'b0;
            if (n == change_at) bus.d_in = 8'hFF;
            tick          = ((ph % period) == period - 1);
            ph++;
            bus.baud_rate = tick;
            @(negedge clk);
            edges++;
            if (tick) n++;
        end
    endtask

    task automatic idle_cycles(input int k);
        bus.tx_start  = 1'b0;
        bus.baud_rate = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic test_reset();
        bit bad;
        reset         = 1'b1;
        bus.tx_start  = 1'b1;
        bus.d_in      = 8'h00;
        bus.baud_rate = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.tx, bus.tx_busy, bus.tx_done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_values got %b want 100", {bus.tx, bus.tx_busy, bus.tx_done});
        end
        reset        = 1'b0;
        bus.tx_start = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({bus.tx, bus.tx_busy, bus.tx_done} !== 3'b100) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL idle_ignores_ticks got %b want 100", {bus.tx, bus.tx_busy, bus.tx_done});
        end
    endtask

    task automatic test_basic();
        int e;
        run_frame("basic_a5", 8'hA5, 4, 0, -1, -1, e);
        n_cmp++;
        if (e !== TOTAL * 4) begin
            n_err++;
            $display("FAIL basic_a5_length got %0d cycles want %0d", e, TOTAL * 4);
        end
        idle_cycles(1);
        n_cmp++;
        if ({bus.tx, bus.tx_busy, bus.tx_done} !== 3'b100) begin
            n_err++;
            $display("FAIL basic_a5_single_done got %b want 100", {bus.tx, bus.tx_busy, bus.tx_done});
        end
    endtask

    task automatic test_hold_start();
        int e;
        run_frame("hold_3c", 8'h3C, 4, 1, 80, -1, e);
        run_frame("hold_second_ff", 8'hFF, 4, 0, -1, -1, e);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int e;
        int c0;
        c0 = rx_done_cnt;
        run_frame("b2b_00", 8'h00, 4, 0, -1, -1, e);
        run_frame("b2b_ff", 8'hFF, 4, 0, -1, -1, e);
        idle_cycles(2);
        n_cmp++;
        if (rx_done_cnt !== c0 + 2 || rx_byte !== 8'hFF) begin
            n_err++;
            $display("FAIL b2b_rx got %0d frames last %h want %0d frames last ff",
                     rx_done_cnt - c0, rx_byte, 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e;
        bit bad;
        run_frame("abort_81", 8'h81, 4, 0, -1, 5 * SB + 6, e);
        n_cmp++;
        if ({bus.tx, bus.tx_busy, bus.tx_done} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_after_reset got %b want 100", {bus.tx, bus.tx_busy, bus.tx_done});
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            bus.baud_rate = ((i % 4) == 3);
            @(negedge clk);
            if ({bus.tx, bus.tx_busy, bus.tx_done} !== 3'b100) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL abort_no_done saw activity after reset, want idle 100");
        end
        run_frame("after_abort_81", 8'h81, 4, 0, -1, -1, e);
        idle_cycles(2);
    endtask

    task automatic test_continuous();
        int e;
        run_frame("cont_55", 8'h55, 1, 0, -1, -1, e);
        n_cmp++;
        if (e !== TOTAL) begin
            n_err++;
            $display("FAIL cont_55_length got %0d cycles want %0d", e, TOTAL);
        end
        idle_cycles(2);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [4];
        int e;
        int c0;
        bytes = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
        foreach (bytes[i]) begin
            c0 = rx_done_cnt;
            run_frame("loop", bytes[i], 4, 0, -1, -1, e);
            idle_cycles(2);
            n_cmp++;
            if (rx_done_cnt !== c0 + 1 || rx_byte !== bytes[i]) begin
                n_err++;
                $display("FAIL loopback byte got %h (%0d frames) want %h (1 frame)",
                         rx_byte, rx_done_cnt - c0, bytes[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int p;
        int e;
        int c0;
        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom_range(0, 255));
            p  = $urandom_range(1, 5);
            c0 = rx_done_cnt;
            run_frame("random", b, p, 0, -1, -1, e);
            idle_cycles($urandom_range(0, 3) + 1);
            n_cmp++;
            if (rx_done_cnt !== c0 + 1 || rx_byte !== b) begin
                n_err++;
                $display("FAIL random_rx period=%0d got %h want %h", p, rx_byte, b);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.tx_start  = 1'b0;
        bus.d_in      = 8'h00;
        bus.baud_rate = 1'b0;
        test_reset();
        test_basic();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_continuous();
        test_loopback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter serialising one byte per request onto `tx`. It pairs with the receiver in the same link: same 16x-oversampled `baud_rate` tick source, one start bit, 8 data bits sent MSB first, one stop bit, no parity. It sits between the host-side byte interface and the serial pin, and reports frame completion with a one-cycle `tx_done` pulse.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: `baud_rate` ticks per bit (start, data and stop bits).

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `baud_rate`  in  1  oversampling tick, 16x the bit rate; one `clk` cycle wide when high; sampled synchronously, never used as a clock.
- `tx_start`  in  1  request to send `d_in`; sampled in IDLE only.
- `d_in`  in  DBIT  byte to transmit; captured in the cycle `tx_start` is accepted.
- `tx`  out  1  serial line, registered; idle high.
- `tx_busy`  out  1  high from acceptance until return to IDLE.
- `tx_done`  out  1  one-cycle pulse at end of stop bit.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, tick counter=0, bit counter=0, shift register=0.
- Internal registers: state (one-hot, 4 states), tick counter 0..SB_TICK-1, bit counter 0..DBIT-1, DBIT-bit shift register.
- IDLE: `tx`=1. If `tx_start`=1, load shift register with `d_in`, clear tick counter, go to START, set `tx_busy`. `baud_rate` is ignored in IDLE.
- START: `tx`=0. On every tick, tick counter +1. On a tick with counter=SB_TICK-1: clear counter, clear bit counter, go to DATA.
- DATA: `tx`=shift register MSB. On a tick with counter=SB_TICK-1: shift left by one, clear counter; if bit counter=DBIT-1 go to STOP, else bit counter +1.
- STOP: `tx`=1. On a tick with counter=SB_TICK-1: clear counter, go to IDLE, pulse `tx_done` for one cycle, clear `tx_busy`.
- `tx_start` outside IDLE is ignored; the frame in progress and its latched data are unaffected by changes on `d_in`.
- `tx_start` in the same cycle as `tx_done`: state is already IDLE in that cycle, so the request is accepted. This gives back-to-back frames with no idle gap beyond one `clk`.
- `reset` overrides everything, including mid-frame. In the cycle after `reset` is sampled high, `tx`=1, and any partial frame is abandoned with no `tx_done`.
- Counter widths: tick counter is `clog2(SB_TICK)` bits; bit counter is `clog2(DBIT)` bits. Neither counter ever wraps past its terminal value.

## Timing
- Acceptance latency: `tx` falls in the first cycle after the edge that samples `tx_start`=1 in IDLE.
- Each bit lasts exactly SB_TICK `baud_rate` ticks, counted from the first tick after entering its state.
- Frame length is (DBIT+2)·SB_TICK ticks = 160 ticks with defaults.
- `tx_done` is high in the cycle following the edge that consumes the final stop-bit tick. `tx_busy` is low in that same cycle.
- Continuous ticks (`baud_rate` held high) are legal: one count per `clk`, so a frame takes 160 cycles plus 1 cycle of acceptance latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `d_in`=0xA5, one `tx_start` pulse, tick every 4 clk -> `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held for 16 ticks (64 clk). Exactly one `tx_done` pulse, 160 ticks after acceptance.
- Hold `tx_start` high throughout a 0x3C frame while changing `d_in` to 0xFF mid-frame -> the transmitted bits remain 0x3C. A second frame starts in the `tx_done` cycle because `tx_start` is still high there.
- Back-to-back 0x00 then 0xFF, with `tx_start` asserted only in the `tx_done` cycle -> the stop bit of frame 1 is followed directly by the start bit of frame 2. `tx_busy` is low for one cycle only.
- Assert `reset` during data bit 3 of 0x81 -> `tx`=1 on the next cycle, `tx_busy`=0, and no `tx_done`. A new 0x81 request afterwards transmits correctly from its start bit.
- `baud_rate` tied high, `d_in`=0x55 -> frame completes in 160 cycles, with `tx_done` on cycle 161 after acceptance.
- Loopback of `tx` into the receiver, sharing `baud_rate`, for bytes 0x00, 0xFF, 0xA5 and 0x3C -> the receiver's `d_out` equals each sent byte, with one `rx_done` per frame.
